// File: rtl/ma_result_drain_pkg.sv
// Shared types and constants for the MA result drain.
// Contents: lane/width constants, lane index type, result-set payload struct,
// drain FSM state enum and a status-word helper.
package ma_result_drain_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = 8;

    typedef logic [LANE_W-1:0] lane_t;

    // One captured result set; sum[i] is lane i.
    typedef struct packed {
        logic [LANES-1:0][WIDTH-1:0] sum;
        logic [LANES-1:0]            inf;
        logic [LANES-1:0]            ovf;
    } result_set_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_STATUS = 2'd2
    } drain_state_e;

    // Summary beat payload: {zeros, overflow mask, isInf mask}.
    function automatic logic [WIDTH-1:0] status_word(input result_set_t s);
        return WIDTH'({s.ovf, s.inf});
    endfunction

endpackage

// File: rtl/ma_result_drain_if.sv
// Write-back beat stream between the result drain and the AFU.
// Signals: out_valid/out_ready handshake, out_data (lane sum), out_lane,
// out_inf/out_ovf (lane flags), out_last (final beat of a set).
// master = drain side (drives beats), slave = consumer side (drives ready).
interface ma_result_drain_if;
    import ma_result_drain_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    lane_t            out_lane;
    logic             out_inf;
    logic             out_ovf;
    logic             out_last;

    modport master (
        output out_valid, out_data, out_lane, out_inf, out_ovf, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_lane, out_inf, out_ovf, out_last,
        output out_ready
    );

endinterface

// File: rtl/ma_result_drain_fifo.sv
// ma_result_fifo: DEPTH-entry result-set FIFO with same-cycle push+pop when full.
// Ports: clk, rst_n; push_i/wdata_i write side; pop_i read side;
//   full_o      registered full flag
//   nxt_empty_c occupancy after this edge is zero (combinational)
//   nxt_head_c  head entry as it will be after this edge (combinational),
//               including bypass of a push into an empty/draining FIFO.
module ma_result_fifo
    import ma_result_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  result_set_t wdata_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        nxt_empty_c,
    output result_set_t nxt_head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W_F = $clog2(DEPTH + 1);

    result_set_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W_F-1:0] count_q, count_d;
    logic               full_q;
    logic               push_eff, pop_eff;

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign pop_eff  = pop_i && (count_q != '0);
    assign push_eff = push_i && (!full_q || pop_eff);

    // Pointer/occupancy next state; DEPTH is a power of two so pointers wrap.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W_F'(push_eff) - CNT_W_F'(pop_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W_F'(DEPTH));
        end
    end

    // Payload storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Look-ahead head: bypass the write when it lands on the new head slot.
    always_comb begin
        if (push_eff && (wr_ptr_q == rd_ptr_d)) nxt_head_c = wdata_i;
        else                                    nxt_head_c = mem_q[rd_ptr_d];
    end

    assign nxt_empty_c = (count_d == '0);
    assign full_o      = full_q;

endmodule

// File: rtl/ma_result_drain.sv
// ma_result_drain: consumer end of the 8-lane MA group's result interface.
// Captures a result set when every finish_out bit is high, buffers DEPTH sets
// and serializes them one lane per beat on drain_if (master modport).
// Ports: clk, rst_n (async, active-low); sum/isInf/overflow/finish_out from the
//   MA group; drain_if beat stream; drop_err/skew_err sticky flags; drop_cnt
//   saturating count of sets lost to a full buffer.
// Option: MA_DRAIN_STATUS_WORD_EN adds a per-set status beat carrying the
//   overflow/isInf masks after lane LANES-1.
module ma_result_drain
    import ma_result_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*WIDTH-1:0] sum,
    input  logic [LANES-1:0]       isInf,
    input  logic [LANES-1:0]       overflow,
    input  logic [LANES-1:0]       finish_out,
    ma_result_drain_if.master      drain_if,
    output logic                   drop_err,
    output logic                   skew_err,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

    drain_state_e     state_q, state_d;
    lane_t            lane_q, lane_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    lane_t            out_lane_q, out_lane_d;
    logic             out_inf_q, out_inf_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_last_q, out_last_d;
    logic             drop_err_q, drop_err_d;
    logic             skew_err_q, skew_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        capture_c, skew_c, xfer_c, final_beat_c, pop_c, push_c, drop_c;
    logic        fifo_full, fifo_nxt_empty;
    result_set_t cap_set_c, nxt_head;

    assign cap_set_c = {sum, isInf, overflow};
    assign capture_c = &finish_out;
    assign skew_c    = (|finish_out) && !capture_c;
    assign xfer_c    = out_valid_q && drain_if.out_ready;

    // The beat that retires the head set.
`ifdef MA_DRAIN_STATUS_WORD_EN
    assign final_beat_c = (state_q == ST_STATUS);
`else
    assign final_beat_c = (state_q == ST_STREAM) && (lane_q == LAST_LANE);
`endif
    assign pop_c  = xfer_c && final_beat_c;
    // A full buffer still accepts when its head leaves in the same cycle.
    assign push_c = capture_c && (!fifo_full || pop_c);
    assign drop_c = capture_c && fifo_full && !pop_c;

    ma_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .wdata_i     (cap_set_c),
        .pop_i       (pop_c),
        .full_o      (fifo_full),
        .nxt_empty_c (fifo_nxt_empty),
        .nxt_head_c  (nxt_head)
    );

    // Drain FSM next state and lane pointer.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE: begin
                lane_d = '0;
                if (!fifo_nxt_empty) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer_c) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
`ifdef MA_DRAIN_STATUS_WORD_EN
                        state_d = ST_STATUS;
`else
                        state_d = fifo_nxt_empty ? ST_IDLE : ST_STREAM;
`endif
                    end else begin
                        lane_d = lane_q + lane_t'(1);
                    end
                end
            end
`ifdef MA_DRAIN_STATUS_WORD_EN
            ST_STATUS: begin
                if (xfer_c) begin
                    lane_d  = '0;
                    state_d = fifo_nxt_empty ? ST_IDLE : ST_STREAM;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                lane_d  = '0;
            end
        endcase
    end

    // Next beat, built from the post-edge state and head so outputs stay registered.
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_lane_d  = '0;
        out_inf_d   = 1'b0;
        out_ovf_d   = 1'b0;
        out_last_d  = 1'b0;
        case (state_d)
            ST_STREAM: begin
                out_valid_d = 1'b1;
                out_data_d  = nxt_head.sum[lane_d];
                out_lane_d  = lane_d;
                out_inf_d   = nxt_head.inf[lane_d];
                out_ovf_d   = nxt_head.ovf[lane_d];
`ifndef MA_DRAIN_STATUS_WORD_EN
                out_last_d  = (lane_d == LAST_LANE);
`endif
            end
`ifdef MA_DRAIN_STATUS_WORD_EN
            ST_STATUS: begin
                out_valid_d = 1'b1;
                out_data_d  = status_word(nxt_head);
                out_inf_d   = |nxt_head.inf;
                out_ovf_d   = |nxt_head.ovf;
                out_last_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sticky error flags and saturating drop counter.
    always_comb begin
        drop_err_d = drop_err_q || drop_c;
        skew_err_d = skew_err_q || skew_c;
        drop_cnt_d = drop_cnt_q;
        if (drop_c && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_inf_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_last_q  <= 1'b0;
            drop_err_q  <= 1'b0;
            skew_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_inf_q   <= out_inf_d;
            out_ovf_q   <= out_ovf_d;
            out_last_q  <= out_last_d;
            drop_err_q  <= drop_err_d;
            skew_err_q  <= skew_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign drain_if.out_valid = out_valid_q;
    assign drain_if.out_data  = out_data_q;
    assign drain_if.out_lane  = out_lane_q;
    assign drain_if.out_inf   = out_inf_q;
    assign drain_if.out_ovf   = out_ovf_q;
    assign drain_if.out_last  = out_last_q;
    assign drop_err           = drop_err_q;
    assign skew_err           = skew_err_q;
    assign drop_cnt           = drop_cnt_q;

endmodule
